// File: rtl/coefficient_calculator_cu_if.sv
`default_nettype none
// ============================================================================
// Module   : coefficient_calculator_cu_if
// Purpose  : Start/done handshake, sample-memory read port and datapath load
//            strobes between the regression control unit and its datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface coefficient_calculator_cu_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              dp_clr;
    logic              ldx;
    logic              ldy;
    logic              ldx_sum;
    logic              ldy_sum;
    logic              select1;
    logic              ldx_mean;
    logic              ldy_mean;
    logic              ldssxx;
    logic              ldssxy;
    logic              ldb1;
    logic              ldb0;
    logic              pass;

    modport master (
        input  start,
        output busy, done, mem_rd, mem_addr, dp_clr, ldx, ldy, ldx_sum, ldy_sum,
               select1, ldx_mean, ldy_mean, ldssxx, ldssxy, ldb1, ldb0, pass
    );

    modport slave (
        output start,
        input  busy, done, mem_rd, mem_addr, dp_clr, ldx, ldy, ldx_sum, ldy_sum,
               select1, ldx_mean, ldy_mean, ldssxx, ldssxy, ldb1, ldb0, pass
    );
endinterface
`default_nettype wire

// File: rtl/coefficient_calculator_cu.sv
`default_nettype none
// ============================================================================
// Module   : coefficient_calculator_cu
// Purpose  : Two-pass sequencer for the linear-regression coefficient datapath
//            (sums/means, then SSxx/SSxy, then b1 and b0).
// Revision : 1.0 - initial release
// ============================================================================
module coefficient_calculator_cu #(
    parameter int N_SAMPLES = 150,
    parameter int ADDR_W    = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    coefficient_calculator_cu_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CLR    = 4'd1,
        S_P1_RD  = 4'd2,
        S_P1_LD  = 4'd3,
        S_P1_ACC = 4'd4,
        S_MEAN_X = 4'd5,
        S_MEAN_Y = 4'd6,
        S_P2_RD  = 4'd7,
        S_P2_LD  = 4'd8,
        S_P2_ACC = 4'd9,
        S_B1     = 4'd10,
        S_B0     = 4'd11,
        S_DONE   = 4'd12
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(N_SAMPLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              pass_q, pass_d;

    logic busy_q, done_q, mem_rd_q, dp_clr_q, ldx_q, ldy_q, ldx_sum_q, ldy_sum_q;
    logic select1_q, ldx_mean_q, ldy_mean_q, ldssxx_q, ldssxy_q, ldb1_q, ldb0_q;
    logic busy_d, done_d, mem_rd_d, dp_clr_d, ldx_d, ldy_d, ldx_sum_d, ldy_sum_d;
    logic select1_d, ldx_mean_d, ldy_mean_d, ldssxx_d, ldssxy_d, ldb1_d, ldb0_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_CLR;
            S_CLR:    begin cnt_d = '0; pass_d = 1'b0; state_d = S_P1_RD; end
            S_P1_RD:  state_d = S_P1_LD;
            S_P1_LD:  state_d = S_P1_ACC;
            S_P1_ACC: begin
                if (cnt_q == c_LAST_IDX) begin
                    state_d = S_MEAN_X;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = S_P1_RD;
                end
            end
            S_MEAN_X: state_d = S_MEAN_Y;
            S_MEAN_Y: begin cnt_d = '0; pass_d = 1'b1; state_d = S_P2_RD; end
            S_P2_RD:  state_d = S_P2_LD;
            S_P2_LD:  state_d = S_P2_ACC;
            S_P2_ACC: begin
                if (cnt_q == c_LAST_IDX) begin
                    state_d = S_B1;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                    state_d = S_P2_RD;
                end
            end
            S_B1:     state_d = S_B0;
            S_B0:     state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the registered copies are
    // exactly the Moore outputs of the state being entered.
    always_comb begin
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        mem_rd_d   = (state_d == S_P1_RD)  || (state_d == S_P2_RD);
        dp_clr_d   = (state_d == S_CLR);
        ldx_d      = (state_d == S_P1_LD)  || (state_d == S_P2_LD);
        ldy_d      = ldx_d;
        ldx_sum_d  = (state_d == S_P1_ACC);
        ldy_sum_d  = ldx_sum_d;
        select1_d  = (state_d == S_MEAN_Y);
        ldx_mean_d = (state_d == S_MEAN_X);
        ldy_mean_d = (state_d == S_MEAN_Y);
        ldssxx_d   = (state_d == S_P2_ACC);
        ldssxy_d   = ldssxx_d;
        ldb1_d     = (state_d == S_B1);
        ldb0_d     = (state_d == S_B0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            dp_clr_q   <= 1'b0;
            ldx_q      <= 1'b0;
            ldy_q      <= 1'b0;
            ldx_sum_q  <= 1'b0;
            ldy_sum_q  <= 1'b0;
            select1_q  <= 1'b0;
            ldx_mean_q <= 1'b0;
            ldy_mean_q <= 1'b0;
            ldssxx_q   <= 1'b0;
            ldssxy_q   <= 1'b0;
            ldb1_q     <= 1'b0;
            ldb0_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rd_q   <= mem_rd_d;
            dp_clr_q   <= dp_clr_d;
            ldx_q      <= ldx_d;
            ldy_q      <= ldy_d;
            ldx_sum_q  <= ldx_sum_d;
            ldy_sum_q  <= ldy_sum_d;
            select1_q  <= select1_d;
            ldx_mean_q <= ldx_mean_d;
            ldy_mean_q <= ldy_mean_d;
            ldssxx_q   <= ldssxx_d;
            ldssxy_q   <= ldssxy_d;
            ldb1_q     <= ldb1_d;
            ldb0_q     <= ldb0_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = cnt_q;
    assign bus.dp_clr   = dp_clr_q;
    assign bus.ldx      = ldx_q;
    assign bus.ldy      = ldy_q;
    assign bus.ldx_sum  = ldx_sum_q;
    assign bus.ldy_sum  = ldy_sum_q;
    assign bus.select1  = select1_q;
    assign bus.ldx_mean = ldx_mean_q;
    assign bus.ldy_mean = ldy_mean_q;
    assign bus.ldssxx   = ldssxx_q;
    assign bus.ldssxy   = ldssxy_q;
    assign bus.ldb1     = ldb1_q;
    assign bus.ldb0     = ldb0_q;
    assign bus.pass     = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_coefficient_calculator_cu.sv
`default_nettype none
// ============================================================================
// Module   : tb_coefficient_calculator_cu
// Purpose  : Scoreboard bench for the regression control unit at N=150/4/1/256
//            with a behavioural datapath and sample memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coefficient_calculator_cu;

    localparam int NI = 4;
    localparam int NS [NI] = '{150, 4, 1, 256};
    localparam int K_CLR = 0, K_RD = 1, K_XM = 2, K_YM = 3, K_B1 = 4, K_B0 = 5, K_DN = 6;

    typedef struct {
        int inst;
        int kind;
        int cyc;
        int addr;
        int aux;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI-1:0] start_v = '0;
    int            cyc = 0;

    logic [NI-1:0] busy_w, done_w, rd_w, clr_w, ldx_w, ldy_w, ldxs_w, ldys_w;
    logic [NI-1:0] sel_w, ldxm_w, ldym_w, ldsxx_w, ldsxy_w, ldb1_w, ldb0_w, pass_w;
    logic [7:0]    addr_w [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        coefficient_calculator_cu_if #(.ADDR_W(8)) u_if ();
        coefficient_calculator_cu #(.N_SAMPLES(NS[g]), .ADDR_W(8)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if)
        );
        assign u_if.start = start_v[g];
        assign busy_w[g]  = u_if.busy;
        assign done_w[g]  = u_if.done;
        assign rd_w[g]    = u_if.mem_rd;
        assign clr_w[g]   = u_if.dp_clr;
        assign ldx_w[g]   = u_if.ldx;
        assign ldy_w[g]   = u_if.ldy;
        assign ldxs_w[g]  = u_if.ldx_sum;
        assign ldys_w[g]  = u_if.ldy_sum;
        assign sel_w[g]   = u_if.select1;
        assign ldxm_w[g]  = u_if.ldx_mean;
        assign ldym_w[g]  = u_if.ldy_mean;
        assign ldsxx_w[g] = u_if.ldssxx;
        assign ldsxy_w[g] = u_if.ldssxy;
        assign ldb1_w[g]  = u_if.ldb1;
        assign ldb0_w[g]  = u_if.ldb0;
        assign pass_w[g]  = u_if.pass;
        assign addr_w[g]  = u_if.mem_addr;
    end

    ev_t sbq [$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  ovl_err = 0;
    int  busy_err = 0;
    bit  in_run [NI];

    task automatic check(input bit ok, input string nm, input string act, input string exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", nm, act, exp);
    endtask

    function automatic logic [23:0] outs(input int i);
        return {busy_w[i], done_w[i], rd_w[i], clr_w[i], ldx_w[i], ldy_w[i], ldxs_w[i],
                ldys_w[i], sel_w[i], ldxm_w[i], ldym_w[i], ldsxx_w[i], ldsxy_w[i],
                ldb1_w[i], ldb0_w[i], pass_w[i], addr_w[i]};
    endfunction

    // ---------------- monitor: pops the scoreboard on every phase strobe
    task automatic observe(input int i, input int kind, input int addr, input int aux);
        ev_t   e;
        string a;
        a = $sformatf("inst%0d kind%0d cyc%0d addr%0d aux%0d", i, kind, cyc, addr, aux);
        if (sbq.size() == 0) begin
            check(1'b0, "unexpected_strobe", a, "no strobe");
        end else begin
            e = sbq.pop_front();
            check(e.inst == i && e.kind == kind && e.cyc == cyc && e.addr == addr && e.aux == aux,
                  "strobe_event", a,
                  $sformatf("inst%0d kind%0d cyc%0d addr%0d aux%0d", e.inst, e.kind, e.cyc, e.addr, e.aux));
        end
    endtask

    always @(negedge clk) begin
        int ns;
        int ax;
        for (int i = 0; i < NI; i++) begin
            ns = int'(clr_w[i]) + int'(rd_w[i]) + int'(ldx_w[i]) + int'(ldxs_w[i]) + int'(ldxm_w[i])
               + int'(ldym_w[i]) + int'(ldsxx_w[i]) + int'(ldb1_w[i]) + int'(ldb0_w[i]) + int'(done_w[i]);
            if (ns > 1) ovl_err++;
            if (clr_w[i] === 1'b1) in_run[i] = 1'b1;
            if (busy_w[i] !== in_run[i]) busy_err++;
            ax = 2 * int'(pass_w[i]) + int'(sel_w[i]);
            if (clr_w[i] === 1'b1)  observe(i, K_CLR, 0, int'(sel_w[i]));
            if (rd_w[i] === 1'b1)   observe(i, K_RD, int'(addr_w[i]), ax);
            if (ldxm_w[i] === 1'b1) observe(i, K_XM, 0, ax);
            if (ldym_w[i] === 1'b1) observe(i, K_YM, 0, ax);
            if (ldb1_w[i] === 1'b1) observe(i, K_B1, 0, ax);
            if (ldb0_w[i] === 1'b1) observe(i, K_B0, 0, ax);
            if (done_w[i] === 1'b1) observe(i, K_DN, 0, ax);
            if (done_w[i] === 1'b1 || rst) in_run[i] = 1'b0;
        end
    end

    // ---------------- behavioural sample memory (x=i, y=2i+5) and datapath
    int  xin [NI];
    int  yin [NI];
    real xr [NI], yr [NI], sx [NI], sy [NI], mx [NI], my [NI];
    real sxx [NI], sxy [NI], b1 [NI], b0 [NI];
    int  nsum [NI], nss [NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (clr_w[i] === 1'b1) begin
                sx[i] = 0.0; sy[i] = 0.0; mx[i] = 0.0; my[i] = 0.0;
                sxx[i] = 0.0; sxy[i] = 0.0; b1[i] = 0.0; b0[i] = 0.0;
                nsum[i] = 0; nss[i] = 0;
            end else begin
                // Register semantics: each update consumes values loaded in earlier cycles.
                if (ldb0_w[i] === 1'b1) b0[i] = my[i] - b1[i] * mx[i];
                if (ldb1_w[i] === 1'b1) b1[i] = (sxx[i] != 0.0) ? sxy[i] / sxx[i] : 0.0;
                if (ldsxx_w[i] === 1'b1) begin
                    sxx[i] = sxx[i] + (xr[i] - mx[i]) * (xr[i] - mx[i]);
                    nss[i] = nss[i] + 1;
                end
                if (ldsxy_w[i] === 1'b1) sxy[i] = sxy[i] + (xr[i] - mx[i]) * (yr[i] - my[i]);
                if (ldxm_w[i] === 1'b1) mx[i] = (sel_w[i] ? sy[i] : sx[i]) / real'(NS[i]);
                if (ldym_w[i] === 1'b1) my[i] = (sel_w[i] ? sy[i] : sx[i]) / real'(NS[i]);
                if (ldxs_w[i] === 1'b1) begin
                    sx[i] = sx[i] + xr[i];
                    nsum[i] = nsum[i] + 1;
                end
                if (ldys_w[i] === 1'b1) sy[i] = sy[i] + yr[i];
                if (ldx_w[i] === 1'b1) xr[i] = real'(xin[i]);
                if (ldy_w[i] === 1'b1) yr[i] = real'(yin[i]);
            end
            if (rd_w[i] === 1'b1) begin
                xin[i] = int'(addr_w[i]);
                yin[i] = 2 * int'(addr_w[i]) + 5;
            end
        end
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int i, input int kind, input int cy, input int addr, input int aux);
        ev_t e;
        e.inst = i; e.kind = kind; e.cyc = cy; e.addr = addr; e.aux = aux;
        sbq.push_back(e);
    endtask

    // Run cycle c (1 = CLR) is observed at cyc == b + c - 1.
    task automatic push_run(input int i, input int b);
        int n;
        n = NS[i];
        push(i, K_CLR, b, 0, 0);
        for (int k = 0; k < n; k++) push(i, K_RD, b + 3 * k + 1, k, 0);
        push(i, K_XM, b + 3 * n + 1, 0, 0);
        push(i, K_YM, b + 3 * n + 2, 0, 1);
        for (int k = 0; k < n; k++) push(i, K_RD, b + 3 * n + 3 * k + 3, k, 2);
        push(i, K_B1, b + 6 * n + 3, 0, 2);
        push(i, K_B0, b + 6 * n + 4, 0, 2);
        push(i, K_DN, b + 6 * n + 5, 0, 2);
    endtask

    task automatic start_run(input int i, input bit hold, output int b);
        start_v[i] = 1'b1;
        b = cyc + 1;
        push_run(i, b);
        if (!hold) begin
            tick();
            start_v[i] = 1'b0;
        end
    endtask

    task automatic drain(input int limit);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < limit) begin
            tick();
            t++;
        end
        if (sbq.size() != 0) begin
            check(1'b0, "run_timeout", $sformatf("%0d events pending", sbq.size()), "0 events pending");
            sbq.delete();
        end
    endtask

    task automatic check_idle(input int i, input int exp_cyc);
        check(busy_w[i] == 1'b0 && cyc == exp_cyc, "idle_after_done",
              $sformatf("busy=%0b cyc=%0d", busy_w[i], cyc), $sformatf("busy=0 cyc=%0d", exp_cyc));
    endtask

    task automatic run_checks(input int i, input bit coef);
        check(ovl_err == 0, "strobe_overlap", $sformatf("%0d", ovl_err), "0");
        check(busy_err == 0, "busy_window", $sformatf("%0d", busy_err), "0");
        ovl_err = 0;
        busy_err = 0;
        check(nsum[i] == NS[i] && nss[i] == NS[i], "acc_pulse_count",
              $sformatf("sum=%0d ss=%0d", nsum[i], nss[i]), $sformatf("sum=%0d ss=%0d", NS[i], NS[i]));
        if (coef) begin
            check((b1[i] - 2.0) < 1.0e-9 && (2.0 - b1[i]) < 1.0e-9, "b1_value",
                  $sformatf("%f", b1[i]), "2.000000");
            check((b0[i] - 5.0) < 1.0e-9 && (5.0 - b0[i]) < 1.0e-9, "b0_value",
                  $sformatf("%f", b0[i]), "5.000000");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int b2;
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        for (int i = 0; i < NI; i++)
            check(outs(i) == 24'd0, "reset_idle_outputs", $sformatf("%h", outs(i)), "000000");

        // Full run N=150: done in cycle 906
        start_run(0, 1'b0, b);
        drain(6 * NS[0] + 40);
        check_idle(0, b + 6 * NS[0] + 6);
        run_checks(0, 1'b1);

        // Strobe ordering N=4
        tick();
        start_run(1, 1'b0, b);
        drain(6 * NS[1] + 40);
        check_idle(1, b + 30);
        run_checks(1, 1'b1);

        // start pulsed during P2_ACC (cycle 21) is ignored
        tick();
        start_run(1, 1'b0, b);
        while (cyc < b + 20) tick();
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        drain(6 * NS[1] + 40);
        check_idle(1, b + 30);
        repeat (5) tick();
        check(busy_w[1] == 1'b0, "start_while_busy_ignored", $sformatf("busy=%0b", busy_w[1]), "busy=0");
        run_checks(1, 1'b1);

        // Mid-run reset in cycle 50 of an N=150 run, then a fresh run
        tick();
        start_run(0, 1'b0, b);
        while (cyc < b + 49) tick();
        rst = 1'b1;
        tick();
        check(outs(0) == 24'd0, "midrun_reset_outputs", $sformatf("%h", outs(0)), "000000");
        rst = 1'b0;
        sbq.delete();
        ovl_err = 0;
        busy_err = 0;
        tick();
        start_run(0, 1'b0, b);
        drain(6 * NS[0] + 40);
        check_idle(0, b + 906);
        run_checks(0, 1'b1);

        // Back-to-back N=1 with start held: second CLR in cycle 14
        tick();
        start_run(2, 1'b1, b);
        push_run(2, b + 13);
        while (cyc < b + 12) tick();
        check(busy_w[2] == 1'b0, "b2b_idle_cycle13", $sformatf("busy=%0b", busy_w[2]), "busy=0");
        tick();
        start_v[2] = 1'b0;
        drain(80);
        b2 = b + 13;
        check_idle(2, b2 + 12);
        run_checks(2, 1'b0);

        // N=256 at ADDR_W=8: last address 255, done in cycle 1542
        tick();
        start_run(3, 1'b0, b);
        drain(6 * NS[3] + 40);
        check_idle(3, b + 1542);
        run_checks(3, 1'b1);

        repeat (3) tick();
        check(sbq.size() == 0, "scoreboard_empty", $sformatf("%0d", sbq.size()), "0");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
